crossbar_gen: RTL
=================

CROSSBAR_GEN -- requirements
Module: crossbar_gen

Interface
REQ-001 Parameter NUM_CONT, default 8: containers per width class; legal range 2..8.
REQ-002 Parameter W6, default 48: width of a 6B-class container.
REQ-003 Parameter W4, default 32: width of a 4B-class container.
REQ-004 Parameter W2, default 16: width of a 2B-class container; must be at least 16.
REQ-005 Parameter ACT_LEN, default 25: width of one sub-action.
REQ-006 Parameter META_W, default 256: width of the trailing metadata field.
REQ-007 Derived constants: PHV_LEN = NUM_CONT*(W6+W4+W2)+META_W; NUM_ACT = 3*NUM_CONT+1; SEL_W = clog2(NUM_CONT).
REQ-008 clk  in  1  clock; all state is updated on the rising edge.
REQ-009 rst_n  in  1  reset; asynchronous, active-low.
REQ-010 phv_in  in  PHV_LEN  PHV; 6B class at the MSB end, then 4B, then 2B, then metadata at [META_W-1:0]; container NUM_CONT-1 is highest within each class.
REQ-011 phv_in_valid  in  1  PHV valid.
REQ-012 action_in  in  NUM_ACT*ACT_LEN  sub-actions; sub-action k = action_in[(k+1)*ACT_LEN-1 -: ACT_LEN].
REQ-013 action_in_valid  in  1  action valid.
REQ-014 ready_out  out  1  input ready.
REQ-015 bypass  in  1  when 1, the beat is forced to pass-through operands; sampled on the accept cycle.
REQ-016 alu_in_6B_1 and alu_in_6B_2  out  NUM_CONT*W6 each  6B operands A and B.
REQ-017 alu_in_4B_1, alu_in_4B_2 and alu_in_4B_3  out  NUM_CONT*W4 each  4B operands A, B and C.
REQ-018 alu_in_2B_1 and alu_in_2B_2  out  NUM_CONT*W2 each  2B operands A and B.
REQ-019 phv_remain_data  out  META_W  metadata pass-through.
REQ-020 action_out  out  NUM_ACT*ACT_LEN  action bits aligned with the operands.
REQ-021 alu_in_valid  out  1  output beat valid; covers the operands, phv_remain_data and action_out.
REQ-022 ready_in  in  1  downstream ready.
REQ-023 err_unpaired  out  1  one-cycle pulse flagging unpaired PHV/action valids.

Function
REQ-024 Accept fires when phv_in_valid && action_in_valid && ready_out; a PHV or action beat arriving alone is never consumed.
REQ-025 Output transfer fires when alu_in_valid && ready_in.
REQ-026 Routing: container i uses sub-action k = 2*NUM_CONT+1+i (6B), NUM_CONT+1+i (4B), or 1+i (2B); sub-action 0 is not decoded.
REQ-027 Sub-action fields: op = [24:21], srcA = [16+SEL_W-1:16], srcB = [11+SEL_W-1:11], imm = [15:0].
REQ-028 6B and 2B decode:
- op 0001 or 0010: A = cont[srcA], B = cont[srcB].
- op 1001 or 1010: A = cont[srcA], B = zero-extended imm.
- op 1110: A = 0, B = zero-extended imm.
- any other op: A = cont[i], B = 0.
REQ-029 4B decode:
- op 0001, 0010, 0100, 0101, 0110, 0111, 1000 or 1011: A = cont[srcA], B = cont[srcB].
- op 1001 or 1010: A = cont[srcA], B = zero-extended imm.
- op 1110: A = 0, B = imm.
- any other op: A = cont[i], B = 0.
- C = cont[i] for every op.
REQ-030 A srcA or srcB value of NUM_CONT or more selects an all-zero operand.
REQ-031 With bypass = 1: every class takes the default case (A = cont[i], B = 0, C = cont[i]); action_out still carries action_in unchanged.
REQ-032 Latency is exactly 1 cycle from accept to alu_in_valid with ready_in held high; throughput is 1 beat per cycle.
REQ-033 Buffering is one output register plus one skid entry; states EMPTY, ONE, FULL:
- EMPTY: accept -> ONE.
- ONE: accept without transfer -> FULL; transfer without accept -> EMPTY; both or neither -> stay in ONE.
- FULL: transfer moves the skid entry to the output -> ONE.
REQ-034 ready_out is registered and equals (state != FULL), so it never depends combinationally on ready_in.
REQ-035 While alu_in_valid = 1 and ready_in = 0, every output holds stable.
REQ-036 Beats are never dropped, duplicated or reordered.
REQ-037 err_unpaired pulses one cycle after any cycle in which ready_out = 1 and phv_in_valid differs from action_in_valid.

Reset
REQ-038 rst_n low asynchronously clears alu_in_valid, err_unpaired and all operand, metadata and action outputs to 0, empties the skid entry, sets state to EMPTY and sets ready_out to 1.
REQ-039 Reset asserted mid-stream discards all buffered beats; the first accept after release produces alu_in_valid on the following cycle.

Verification
REQ-040 Defaults, 6B container 3, op 1001, srcA 5, imm 0x00AB, ready_in = 1 -> one cycle later: A slice 3 = cont6[5], B slice 3 = 0x0000_0000_00AB, alu_in_valid = 1.
REQ-041 4B container 2, op 1110, imm 0x1234 -> A = 0, B = 0x0000_1234, C = cont4[2]; all other containers with op 0000 -> A = cont[i], B = 0.
REQ-042 NUM_CONT = 6, 2B op 0001 with srcA 7 -> A = 0.
REQ-043 Stream 4 beats, ready_in low for 3 cycles after beat 1:
- ready_out falls only after the skid entry fills.
- Outputs hold stable while stalled.
- Beats 1..4 emerge in order with none lost.
REQ-044 Unpaired valids and bypass:
- phv_in_valid = 1, action_in_valid = 0 for 2 cycles -> no accept, err_unpaired pulses twice.
- Then bypass = 1 with both valids high -> operands equal pass-through values.
REQ-045 rst_n pulsed low while in FULL -> alu_in_valid = 0 and ready_out = 1 immediately; no stale beat appears after release.

Source files
------------

// File: rtl/crossbar_gen.sv
// Operand crossbar: routes PHV containers to ALU operand buses under
// control of per-container sub-actions, behind a registered output stage
// with one skid entry so ready_out never depends on ready_in.
module crossbar_gen #(
  parameter int unsigned NUM_CONT = 8,
  parameter int unsigned W6       = 48,
  parameter int unsigned W4       = 32,
  parameter int unsigned W2       = 16,
  parameter int unsigned ACT_LEN  = 25,
  parameter int unsigned META_W   = 256,
  localparam int unsigned PHV_LEN = NUM_CONT * (W6 + W4 + W2) + META_W,
  localparam int unsigned NUM_ACT = 3 * NUM_CONT + 1,
  localparam int unsigned SEL_W   = $clog2(NUM_CONT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [PHV_LEN-1:0]           phv_in,
  input  logic                         phv_in_valid,
  input  logic [NUM_ACT*ACT_LEN-1:0]   action_in,
  input  logic                         action_in_valid,
  output logic                         ready_out,
  input  logic                         bypass,
  output logic [NUM_CONT*W6-1:0]       alu_in_6B_1,
  output logic [NUM_CONT*W6-1:0]       alu_in_6B_2,
  output logic [NUM_CONT*W4-1:0]       alu_in_4B_1,
  output logic [NUM_CONT*W4-1:0]       alu_in_4B_2,
  output logic [NUM_CONT*W4-1:0]       alu_in_4B_3,
  output logic [NUM_CONT*W2-1:0]       alu_in_2B_1,
  output logic [NUM_CONT*W2-1:0]       alu_in_2B_2,
  output logic [META_W-1:0]            phv_remain_data,
  output logic [NUM_ACT*ACT_LEN-1:0]   action_out,
  output logic                         alu_in_valid,
  input  logic                         ready_in,
  output logic                         err_unpaired
);

  // PHV container base offsets
  localparam int unsigned Off2 = META_W;
  localparam int unsigned Off4 = Off2 + NUM_CONT * W2;
  localparam int unsigned Off6 = Off4 + NUM_CONT * W4;

  // Sub-action base indices per class
  localparam int unsigned K6 = 2 * NUM_CONT + 1;
  localparam int unsigned K4 = NUM_CONT + 1;
  localparam int unsigned K2 = 1;

  // Beat layout, LSB first: action, metadata, B2, A2, C4, B4, A4, B6, A6
  localparam int unsigned ActW   = NUM_ACT * ACT_LEN;
  localparam int unsigned BMeta  = ActW;
  localparam int unsigned BB2    = BMeta + META_W;
  localparam int unsigned BA2    = BB2 + NUM_CONT * W2;
  localparam int unsigned BC4    = BA2 + NUM_CONT * W2;
  localparam int unsigned BB4    = BC4 + NUM_CONT * W4;
  localparam int unsigned BA4    = BB4 + NUM_CONT * W4;
  localparam int unsigned BB6    = BA4 + NUM_CONT * W4;
  localparam int unsigned BA6    = BB6 + NUM_CONT * W6;
  localparam int unsigned BeatW  = BA6 + NUM_CONT * W6;

  // One extra bit so the out-of-range compare also works at NUM_CONT = 2^SEL_W
  localparam logic [SEL_W:0] NumContS = (SEL_W + 1)'(NUM_CONT);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  logic [W6-1:0] c6 [NUM_CONT];
  logic [W4-1:0] c4 [NUM_CONT];
  logic [W2-1:0] c2 [NUM_CONT];

  logic [NUM_CONT*W6-1:0] dec_a6, dec_b6;
  logic [NUM_CONT*W4-1:0] dec_a4, dec_b4, dec_c4;
  logic [NUM_CONT*W2-1:0] dec_a2, dec_b2;

  logic [BeatW-1:0] beat_in;
  logic [BeatW-1:0] out_d, out_q;
  logic [BeatW-1:0] skid_d, skid_q;
  state_e           state_d, state_q;
  logic             ready_d, ready_q;
  logic             err_d, err_q;
  logic             accept, xfer;

  for (genvar i = 0; i < NUM_CONT; i++) begin : g_cont
    assign c6[i] = phv_in[Off6 + i*W6 +: W6];
    assign c4[i] = phv_in[Off4 + i*W4 +: W4];
    assign c2[i] = phv_in[Off2 + i*W2 +: W2];

    // Bypass maps every op onto the pass-through default
    logic [3:0]       op6, op4, op2;
    logic [SEL_W-1:0] sa6, sb6, sa4, sb4, sa2, sb2;
    logic [15:0]      imm6, imm4, imm2;
    logic [W6-1:0]    src6a, src6b, a6, b6;
    logic [W4-1:0]    src4a, src4b, a4, b4;
    logic [W2-1:0]    src2a, src2b, a2, b2;

    assign op6  = bypass ? 4'b0000 : action_in[(K6+i)*ACT_LEN + 21 +: 4];
    assign sa6  = action_in[(K6+i)*ACT_LEN + 16 +: SEL_W];
    assign sb6  = action_in[(K6+i)*ACT_LEN + 11 +: SEL_W];
    assign imm6 = action_in[(K6+i)*ACT_LEN +: 16];

    assign op4  = bypass ? 4'b0000 : action_in[(K4+i)*ACT_LEN + 21 +: 4];
    assign sa4  = action_in[(K4+i)*ACT_LEN + 16 +: SEL_W];
    assign sb4  = action_in[(K4+i)*ACT_LEN + 11 +: SEL_W];
    assign imm4 = action_in[(K4+i)*ACT_LEN +: 16];

    assign op2  = bypass ? 4'b0000 : action_in[(K2+i)*ACT_LEN + 21 +: 4];
    assign sa2  = action_in[(K2+i)*ACT_LEN + 16 +: SEL_W];
    assign sb2  = action_in[(K2+i)*ACT_LEN + 11 +: SEL_W];
    assign imm2 = action_in[(K2+i)*ACT_LEN +: 16];

    // Out-of-range selectors yield a zero operand
    assign src6a = ({1'b0, sa6} < NumContS) ? c6[sa6] : '0;
    assign src6b = ({1'b0, sb6} < NumContS) ? c6[sb6] : '0;
    assign src4a = ({1'b0, sa4} < NumContS) ? c4[sa4] : '0;
    assign src4b = ({1'b0, sb4} < NumContS) ? c4[sb4] : '0;
    assign src2a = ({1'b0, sa2} < NumContS) ? c2[sa2] : '0;
    assign src2b = ({1'b0, sb2} < NumContS) ? c2[sb2] : '0;

    // 6B operand decode
    always_comb begin
      a6 = c6[i];
      b6 = '0;
      case (op6)
        4'b0001, 4'b0010: begin a6 = src6a; b6 = src6b;     end
        4'b1001, 4'b1010: begin a6 = src6a; b6 = W6'(imm6); end
        4'b1110:          begin a6 = '0;    b6 = W6'(imm6); end
        default: ;
      endcase
    end

    // 4B operand decode; the 4B class also supports the logic/compare ops
    always_comb begin
      a4 = c4[i];
      b4 = '0;
      case (op4)
        4'b0001, 4'b0010, 4'b0100, 4'b0101,
        4'b0110, 4'b0111, 4'b1000, 4'b1011: begin a4 = src4a; b4 = src4b; end
        4'b1001, 4'b1010: begin a4 = src4a; b4 = W4'(imm4); end
        4'b1110:          begin a4 = '0;    b4 = W4'(imm4); end
        default: ;
      endcase
    end

    // 2B operand decode
    always_comb begin
      a2 = c2[i];
      b2 = '0;
      case (op2)
        4'b0001, 4'b0010: begin a2 = src2a; b2 = src2b;     end
        4'b1001, 4'b1010: begin a2 = src2a; b2 = W2'(imm2); end
        4'b1110:          begin a2 = '0;    b2 = W2'(imm2); end
        default: ;
      endcase
    end

    assign dec_a6[i*W6 +: W6] = a6;
    assign dec_b6[i*W6 +: W6] = b6;
    assign dec_a4[i*W4 +: W4] = a4;
    assign dec_b4[i*W4 +: W4] = b4;
    assign dec_c4[i*W4 +: W4] = c4[i];
    assign dec_a2[i*W2 +: W2] = a2;
    assign dec_b2[i*W2 +: W2] = b2;
  end

  assign beat_in = {dec_a6, dec_b6, dec_a4, dec_b4, dec_c4, dec_a2, dec_b2,
                    phv_in[META_W-1:0], action_in};

  assign alu_in_valid = (state_q != StEmpty);
  assign ready_out    = ready_q;
  assign err_unpaired = err_q;
  assign accept       = phv_in_valid & action_in_valid & ready_q;
  assign xfer         = alu_in_valid & ready_in;

  // Output register / skid entry control
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          out_d   = beat_in;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && !xfer) begin
          skid_d  = beat_in;
          state_d = StFull;
        end else if (accept && xfer) begin
          out_d = beat_in;
        end else if (xfer) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (xfer) begin
          out_d   = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    ready_d = (state_d != StFull);
    err_d   = ready_q & (phv_in_valid ^ action_in_valid);
  end

  // State, data and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign alu_in_6B_1     = out_q[BA6 +: NUM_CONT*W6];
  assign alu_in_6B_2     = out_q[BB6 +: NUM_CONT*W6];
  assign alu_in_4B_1     = out_q[BA4 +: NUM_CONT*W4];
  assign alu_in_4B_2     = out_q[BB4 +: NUM_CONT*W4];
  assign alu_in_4B_3     = out_q[BC4 +: NUM_CONT*W4];
  assign alu_in_2B_1     = out_q[BA2 +: NUM_CONT*W2];
  assign alu_in_2B_2     = out_q[BB2 +: NUM_CONT*W2];
  assign phv_remain_data = out_q[BMeta +: META_W];
  assign action_out      = out_q[0 +: ActW];

endmodule
